// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// A flush loads all-zero control fields into a stage register, i.e. a bubble.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN,
        DIV_WAIT
    } state_e;

    localparam int unsigned DivCyclesDefault = 33;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic div_start;
        logic div_abort;
    } hz_ctrl_t;

    localparam hz_ctrl_t CtrlOff = '0;

    // All stage registers load; optionally every one of them loads a bubble.
    function automatic hz_ctrl_t ctrl_advance(input logic flush);
        hz_ctrl_t c;
        c              = CtrlOff;
        c.pc_en        = 1'b1;
        c.if_id_en     = 1'b1;
        c.id_ex_en     = 1'b1;
        c.ex_mem_en    = 1'b1;
        c.if_id_flush  = flush;
        c.id_ex_flush  = flush;
        c.ex_mem_flush = flush;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and stage-register controls back to it.
interface pipeline_hazard_ctrl_if;

    logic        redirect_i;
    logic        ex_is_div_i;
    logic        ex_div_by_zero_i;
    logic        ex_mem_read_i;
    logic [4:0]  ex_rd_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        id_uses_rs1_i;
    logic        id_uses_rs2_i;

    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        div_start;
    logic        div_abort;
    logic        div_busy;
    logic [31:0] stall_cycles;

    // Controller side.
    modport master (
        input  redirect_i, ex_is_div_i, ex_div_by_zero_i, ex_mem_read_i, ex_rd_i,
        input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush,
        output div_start, div_abort, div_busy, stall_cycles
    );

    // Pipeline side.
    modport slave (
        output redirect_i, ex_is_div_i, ex_div_by_zero_i, ex_mem_read_i, ex_rd_i,
        output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush,
        input  div_start, div_abort, div_busy, stall_cycles
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources of ID.
module load_use_detect (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_uses_rs1_i && (ex_rd_i == id_rs1_i);
        rs2_hit  = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
        // x0 is never a real dependency.
        hazard_o = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: redirects, multi-cycle divide, load-use, stall counter.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DivCyclesDefault,
    parameter int unsigned CNT_W      = 6
) (
    input logic                  CLK,
    input logic                  RESET,
    pipeline_hazard_ctrl_if.master hz
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic             load_use;
    hz_ctrl_t         ctrl;
    hz_ctrl_t         ctrl_out;

    load_use_detect u_load_use_detect (
        .ex_mem_read_i (hz.ex_mem_read_i),
        .ex_rd_i       (hz.ex_rd_i),
        .id_rs1_i      (hz.id_rs1_i),
        .id_rs2_i      (hz.id_rs2_i),
        .id_uses_rs1_i (hz.id_uses_rs1_i),
        .id_uses_rs2_i (hz.id_uses_rs2_i),
        .hazard_o      (load_use)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = ctrl_advance(1'b0);

        unique case (state_q)
            RUN: begin
                if (hz.redirect_i) begin
                    ctrl = ctrl_advance(1'b1);
                end else if (hz.ex_is_div_i) begin
                    // Freeze PC..ID/EX, feed bubbles into MEM while the divider works.
                    ctrl.div_start    = 1'b1;
                    ctrl.pc_en        = 1'b0;
                    ctrl.if_id_en     = 1'b0;
                    ctrl.id_ex_en     = 1'b0;
                    ctrl.ex_mem_flush = 1'b1;
                    cnt_d   = hz.ex_div_by_zero_i ? '0 : CNT_W'(DIV_CYCLES - 1);
                    state_d = DIV_WAIT;
                end else if (load_use) begin
                    ctrl.pc_en       = 1'b0;
                    ctrl.if_id_en    = 1'b0;
                    ctrl.id_ex_flush = 1'b1;
                end
            end
            DIV_WAIT: begin
                if (hz.redirect_i) begin
                    ctrl           = ctrl_advance(1'b1);
                    ctrl.div_abort = 1'b1;
                    cnt_d          = '0;
                    state_d        = RUN;
                end else if (cnt_q != '0) begin
                    ctrl.pc_en        = 1'b0;
                    ctrl.if_id_en     = 1'b0;
                    ctrl.id_ex_en     = 1'b0;
                    ctrl.ex_mem_flush = 1'b1;
                    cnt_d             = cnt_q - CNT_W'(1);
                end else begin
                    // Release: result valid now; the divide itself must not restart.
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        ctrl_out       = RESET ? CtrlOff : ctrl;
        stall_cycles_d = stall_cycles_q + {31'd0, ~ctrl_out.pc_en};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.pc_en        = ctrl_out.pc_en;
    assign hz.if_id_en     = ctrl_out.if_id_en;
    assign hz.id_ex_en     = ctrl_out.id_ex_en;
    assign hz.ex_mem_en    = ctrl_out.ex_mem_en;
    assign hz.if_id_flush  = ctrl_out.if_id_flush;
    assign hz.id_ex_flush  = ctrl_out.id_ex_flush;
    assign hz.ex_mem_flush = ctrl_out.ex_mem_flush;
    assign hz.div_start    = ctrl_out.div_start;
    assign hz.div_abort    = ctrl_out.div_abort;
    assign hz.div_busy     = (state_q == DIV_WAIT) && !RESET;
    assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage core. It drives the enable and bubble-insert controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It also schedules the multi-cycle divider in EX and resolves load-use hazards and MEM-stage redirects. A free-running stall-cycle counter is exposed for performance monitoring.

## Interface
- DIV_CYCLES, 33, divider latency in cycles for a normal divide (≥2)
- CNT_W, 6, width of the divide countdown (must hold DIV_CYCLES-1)
- CLK  in  1  core clock
- RESET  in  1  asynchronous, active-high reset
- redirect_i  in  1  taken branch or jump resolved in MEM this cycle
- ex_is_div_i  in  1  instruction in EX is DIV/DIVU/REM/REMU
- ex_div_by_zero_i  in  1  EX divide has zero divisor (fast path)
- ex_mem_read_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  destination register of EX instruction
- id_rs1_i, id_rs2_i  in  5 each  source registers of ID instruction
- id_uses_rs1_i, id_uses_rs2_i  in  1 each  ID instruction reads rs1/rs2
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register load enable
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  when enabled, load zeros (bubble) instead of data
- div_start  out  1  one-cycle pulse: divider latches operands
- div_abort  out  1  one-cycle pulse: divider discards work
- div_busy  out  1  high while in DIV_WAIT
- stall_cycles  out  32  count of cycles with pc_en=0

## Operation
- States: RUN, DIV_WAIT. Countdown register cnt[CNT_W-1:0].
- Priority per cycle: redirect > divide > load-use > normal advance.
- Normal (RUN, no event): all enables 1, all flushes 0.
- Redirect (any state): all enables 1; if_id_flush, id_ex_flush, ex_mem_flush = 1. In DIV_WAIT also pulse div_abort and go to RUN. pc_en=1 loads the redirect target.
- Divide start (RUN, ex_is_div_i, no redirect):
  - pulse div_start.
  - pc_en = if_id_en = id_ex_en = 0.
  - ex_mem_en=1 with ex_mem_flush=1.
  - cnt ← DIV_CYCLES-1, or 0 if ex_div_by_zero_i.
  - next state DIV_WAIT.
- DIV_WAIT, cnt≠0: same freeze/bubble as start, cnt decrements.
- DIV_WAIT, cnt=0 (release): divider result valid. All enables 1, flushes 0, next RUN. The next instruction enters EX, so a back-to-back divide starts on the following cycle.
- Load-use (RUN): condition is ex_mem_read_i & ex_rd_i≠0 & ((ex_rd_i==id_rs1_i & id_uses_rs1_i) | (ex_rd_i==id_rs2_i & id_uses_rs2_i)).
  - pc_en = if_id_en = 0.
  - id_ex_en=1 with id_ex_flush=1.
  - ex_mem_en=1.
  - Single cycle; no state change.
- ex_is_div_i and ex_mem_read_i are mutually exclusive by decode. If both are asserted, divide wins.
- stall_cycles increments on every cycle with pc_en=0 and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: state RUN, cnt 0, stall_cycles 0. While RESET is high, all enables, flushes, div_start, div_abort and div_busy are forced to 0.
- Controls are combinational from state and inputs in the same cycle. State, cnt and counter update on the CLK rising edge.
- Normal divide started in cycle N:
  - stall cycles N … N+DIV_CYCLES-1 (DIV_CYCLES total).
  - release in N+DIV_CYCLES; the divider must present its result in that cycle.
- Zero-divisor divide: 1 stall cycle (N), release at N+1.
- Redirect during DIV_WAIT cannot occur in legal flow because MEM holds bubbles. If it does occur, abort is mandatory and is tested.
- RESET asserted mid-divide: immediate return to RUN, cnt cleared, no div_abort pulse. The divider is reset by the same RESET.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - state enum {RUN, DIV_WAIT}.
  - DIV_CYCLES default.
  - the bubble convention: flush means load all-zero control fields.
- Sub-module load_use_detect: purely combinational register-compare, reused later by forwarding logic.
- Top module contains the FSM, the countdown and stall_cycles.

## Test plan
- Reset, then idle RUN with no hazards -> all enables 1, flushes 0, stall_cycles stays 0.
- Load in EX with ex_rd=5, ID uses rs2=5 -> one cycle: pc_en=0, if_id_en=0, id_ex_flush=1, stall_cycles=1. With ex_rd=0 -> no stall.
- Divide with DIV_CYCLES=33 at cycle N -> div_start only at N, div_busy N+1…N+33, release at N+33, stall_cycles=33. Back-to-back second divide -> div_start at N+34.
- Divide with ex_div_by_zero_i=1 -> one stall cycle, release next cycle, stall_cycles=1.
- redirect_i together with ex_is_div_i in RUN -> all three flushes 1, no div_start. Forced redirect in DIV_WAIT -> div_abort pulse, state RUN.
- Preload stall_cycles=0xFFFFFFFF, then stall once -> wraps to 0. Assert RESET mid-divide -> all outputs 0 immediately, RUN after release.
